safe_mode_ctrl_mux: RTL and testbench
=====================================

Name: safe_mode_ctrl_mux

Overview:
- Parametrised, stateful successor to the combinational safe-control mux.
- Sits between control decode and the write-enable sinks: PC, register file, data memory, plus extra channels.
- Filters the fault indication and latches safe mode.
- Leaves safe mode only after a software clear handshake followed by a fault-free recovery window; counts safe-mode entries.

Parameters:
N_CTRL, 3, number of control-enable channels (bit0 pc_write, bit1 reg_write, bit2 mem_write, higher bits user-defined)
FILTER_LEN, 2, consecutive fault_in cycles required to enter SAFE from NORMAL (>=1)
RECOVER_LEN, 8, consecutive fault-free cycles spent in RECOVER before returning to NORMAL (>=1)
CNT_W, 8, width of the saturating fault-entry counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
fault_in  input  1  raw fault indication, level
force_safe  input  1  immediate safe-mode request, bypasses the filter
clear_req  input  1  software request to leave SAFE, level
ctrl_normal  input  N_CTRL  control enables from normal decode
ctrl_safe  input  N_CTRL  control enables to use in safe mode
ctrl_out  output  N_CTRL  selected control enables
safe_mode  output  1  high in SAFE or RECOVER
state_o  output  2  00 NORMAL, 01 SAFE, 10 RECOVER (11 unused)
clear_ack  output  1  one-cycle registered pulse when a clear is accepted
fault_count  output  CNT_W  number of SAFE entries, saturating

Behaviour:
- Reset (synchronous, overrides all other inputs, legal in any state): state NORMAL; filter counter, recover counter, fault_count and clear_ack all 0. Outputs after the reset edge: safe_mode=0, ctrl_out=ctrl_normal.
- ctrl_out = safe_mode ? ctrl_safe : ctrl_normal. This is combinational from the registered state; there is no data latency and no glitch on state change.
- safe_mode = (state != NORMAL).
- State transitions:
  - NORMAL:
    - Filter counter increments each cycle fault_in=1 and clears to 0 when fault_in=0.
    - fault_in=1 with filter counter == FILTER_LEN-1 -> SAFE at the next edge.
    - force_safe=1 -> SAFE at the next edge, regardless of the filter.
    - Entry into SAFE clears the filter counter and increments fault_count.
  - SAFE:
    - clear_req=1 with fault_in=0 and force_safe=0 -> RECOVER at the next edge; clear_ack=1 for exactly that next cycle; recover counter cleared.
    - clear_req while fault_in or force_safe is high is ignored: no ack, stay in SAFE.
    - clear_req held high produces only one ack, because state has left SAFE.
  - RECOVER:
    - Recover counter increments each cycle with fault_in=0 and force_safe=0.
    - fault_in=1 or force_safe=1 -> SAFE at the next edge. No filter applies in RECOVER. Recover counter cleared, fault_count incremented.
    - Counter == RECOVER_LEN-1 with no fault -> NORMAL at the next edge.
    - clear_req is ignored in RECOVER.
- Simultaneous events:
  - A fault in the same cycle as RECOVER completion wins: go to SAFE.
  - force_safe and fault_in together count as one entry.
- fault_count: +1 per SAFE entry (from NORMAL or RECOVER); holds at 2^CNT_W-1; cleared only by rst.
- Counter widths: clog2 of FILTER_LEN and RECOVER_LEN, minimum 1 bit.
- Encoding 11 is unreachable; if ever decoded it must go to SAFE (fail-safe), without incrementing fault_count.

Test Plan:
1. Reset, then ctrl_normal=3'b111, ctrl_safe=3'b000, no faults -> ctrl_out=111, safe_mode=0, state_o=00, fault_count=0.
2. fault_in high for 1 cycle, then low -> remains NORMAL, ctrl_out=111; fault_in high for 2 consecutive cycles -> state_o=01 after the 2nd edge, ctrl_out=000, fault_count=1.
3. In SAFE, assert clear_req with fault_in=1 -> no clear_ack, stays 01; drop fault_in -> one clear_ack pulse, state_o=10, safe_mode still 1, ctrl_out=000; after 8 fault-free cycles -> state_o=00, ctrl_out=111.
4. In RECOVER at cycle 5 of 8, pulse fault_in one cycle -> state_o=01 next edge, fault_count=2; a later clear restarts a full 8-cycle window.
5. force_safe single-cycle pulse in NORMAL -> SAFE next edge, fault_count+1; with CNT_W=2, force 5 entries -> fault_count saturates at 3.
6. Assert rst while in SAFE and while in RECOVER -> NORMAL at that edge, fault_count=0, clear_ack=0, ctrl_out=ctrl_normal.

Source files
------------

// File: rtl/safe_mode_ctrl_mux.sv
// safe_mode_ctrl_mux: filtered fault latch that gates control enables into a safe set until a cleared, fault-free recovery window.
module safe_mode_ctrl_mux #(
    parameter int N_CTRL      = 3,
    parameter int FILTER_LEN  = 2,
    parameter int RECOVER_LEN = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fault_in,
    input  logic              force_safe,
    input  logic              clear_req,
    input  logic [N_CTRL-1:0] ctrl_normal,
    input  logic [N_CTRL-1:0] ctrl_safe,
    output logic [N_CTRL-1:0] ctrl_out,
    output logic              safe_mode,
    output logic [1:0]        state_o,
    output logic              clear_ack,
    output logic [CNT_W-1:0]  fault_count
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int RW = (RECOVER_LEN > 1) ? $clog2(RECOVER_LEN) : 1;
    typedef enum logic [1:0] {NORMAL = 2'b00, SAFE = 2'b01, RECOVER = 2'b10, BAD = 2'b11} state_t;
    state_t           r_state;
    logic [FW-1:0]    r_filt;
    logic [RW-1:0]    r_rec;
    logic [CNT_W-1:0] r_count;
    logic             r_ack;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_fault;
    assign w_fault     = fault_in || force_safe;
    assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NORMAL;
            r_filt  <= '0;
            r_rec   <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                NORMAL: begin
                    if (force_safe || (fault_in && r_filt == FW'(FILTER_LEN - 1))) begin
                        r_state <= SAFE;
                        r_filt  <= '0;
                        r_count <= w_count_inc;
                    end else begin
                        r_filt <= fault_in ? r_filt + 1'b1 : '0;
                    end
                end
                SAFE: begin
                    if (clear_req && !w_fault) begin
                        r_state <= RECOVER;
                        r_ack   <= 1'b1;
                        r_rec   <= '0;
                    end
                end
                RECOVER: begin
                    // a fault on the final window cycle still wins over completion
                    if (w_fault) begin
                        r_state <= SAFE;
                        r_rec   <= '0;
                        r_count <= w_count_inc;
                    end else if (r_rec == RW'(RECOVER_LEN - 1)) begin
                        r_state <= NORMAL;
                        r_rec   <= '0;
                    end else begin
                        r_rec <= r_rec + 1'b1;
                    end
                end
                default: r_state <= SAFE;
            endcase
        end
    end
    assign safe_mode   = (r_state != NORMAL);
    assign ctrl_out    = safe_mode ? ctrl_safe : ctrl_normal;
    assign state_o     = r_state;
    assign clear_ack   = r_ack;
    assign fault_count = r_count;
endmodule

// File: tb/tb_safe_mode_ctrl_mux.sv
// tb_safe_mode_ctrl_mux: directed plus random stimulus against a behavioural model, checked through an expectation queue.
module tb_safe_mode_ctrl_mux;
    localparam int N  = 3;
    localparam int FL = 2;
    localparam int RL = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct packed {
        logic [1:0]    st;
        logic          sm;
        logic [N-1:0]  co;
        logic          ack;
        logic [CW-1:0] cnt;
    } exp_t;
    logic clk = 0, rst = 1, fault_in = 0, force_safe = 0, clear_req = 0;
    logic [N-1:0] ctrl_normal = '1, ctrl_safe = '0, ctrl_out;
    logic safe_mode, clear_ack;
    logic [1:0] state_o;
    logic [CW-1:0] fault_count;
    exp_t q[$];
    int checks = 0, errors = 0;
    int m_st = 0, m_streak = 0, m_clean = 0, m_cnt = 0, m_ack = 0;

    safe_mode_ctrl_mux #(.N_CTRL(N), .FILTER_LEN(FL), .RECOVER_LEN(RL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fault_in(fault_in), .force_safe(force_safe), .clear_req(clear_req),
        .ctrl_normal(ctrl_normal), .ctrl_safe(ctrl_safe), .ctrl_out(ctrl_out), .safe_mode(safe_mode),
        .state_o(state_o), .clear_ack(clear_ack), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model works in terms of fault streaks and clean-cycle counts, not counter encodings.
    task automatic step(input logic r, input logic f, input logic fs, input logic cr,
                        input logic [N-1:0] cn, input logic [N-1:0] cs);
        exp_t e;
        @(negedge clk);
        rst = r; fault_in = f; force_safe = fs; clear_req = cr; ctrl_normal = cn; ctrl_safe = cs;
        m_ack = 0;
        if (r) begin
            m_st = 0; m_streak = 0; m_clean = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            m_streak = f ? m_streak + 1 : 0;
            if (fs || m_streak >= FL) begin
                m_st = 1; m_streak = 0; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end
        end else if (m_st == 1) begin
            if (cr && !f && !fs) begin
                m_st = 2; m_ack = 1; m_clean = 0;
            end
        end else begin
            if (f || fs) begin
                m_st = 1; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else begin
                m_clean++;
                if (m_clean >= RL) m_st = 0;
            end
        end
        e.st  = 2'(m_st);
        e.sm  = (m_st != 0);
        e.co  = (m_st != 0) ? cs : cn;
        e.ack = 1'(m_ack);
        e.cnt = CW'(m_cnt);
        q.push_back(e);
    endtask

    task automatic go(input logic f, input logic fs, input logic cr, input int n);
        for (int i = 0; i < n; i++) step(0, f, fs, cr, 3'b111, 3'b000);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state_o", 8'(state_o), 8'(e.st));
                chk("safe_mode", 8'(safe_mode), 8'(e.sm));
                chk("ctrl_out", 8'(ctrl_out), 8'(e.co));
                chk("clear_ack", 8'(clear_ack), 8'(e.ack));
                chk("fault_count", 8'(fault_count), 8'(e.cnt));
            end
        end
    end

    initial begin : driver
        step(1, 0, 0, 0, 3'b111, 3'b000);
        step(1, 1, 1, 1, 3'b111, 3'b000);
        go(0, 0, 0, 3);
        go(1, 0, 0, 1); go(0, 0, 0, 1);
        go(1, 0, 0, 2);
        go(1, 0, 1, 2);
        go(0, 0, 1, 3);
        go(0, 0, 0, 6);
        go(0, 0, 0, 2);
        go(0, 0, 1, 1);
        go(0, 0, 0, 4);
        go(1, 0, 0, 1);
        go(0, 0, 1, 1);
        go(0, 0, 0, 7);
        go(0, 0, 0, 2);
        for (int k = 0; k < 5; k++) begin
            go(0, 1, 0, 1);
            go(0, 0, 1, 1);
            go(0, 0, 0, RL);
        end
        go(0, 1, 0, 1);
        step(1, 0, 0, 0, 3'b101, 3'b010);
        go(1, 1, 0, 1);
        go(0, 0, 1, 1);
        go(0, 0, 0, 3);
        step(1, 0, 0, 0, 3'b110, 3'b001);
        go(0, 0, 0, 2);
        for (int k = 0; k < 3000; k++)
            step(($urandom % 150) == 0, ($urandom % 7) == 0, ($urandom % 25) == 0,
                 ($urandom % 3) == 0, N'($urandom), N'($urandom));
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
